lut_layer_sequencer: RTL and testbench

//  Time-multiplexes one shared LUT-neuron table store across every neuron of a LogicNets layer.
//  - Accepts a packed input activation vector.
//  - For each output neuron in turn: gathers its FAN_IN activations via a connectivity table,

---
 rtl/lut_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_lut_layer_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: walks every neuron through one shared truth-table
// read port, gathering each neuron's fan-in activations through a connectivity table.

module lut_fanin_lane #(
  parameter int IN_FEAT = 16,
  parameter int IW      = 4,
  parameter int BW      = 2
) (
  input  logic [IN_FEAT-1:0][BW-1:0] acts_i,
  input  logic [IW-1:0]              idx_i,
  input  logic                       en_i,
  output logic [BW-1:0]              act_o,
  output logic                       oob_o
);
  // Compare-select instead of a direct index so an out-of-range idx reads as 0.
  always_comb begin
    act_o = '0;
    for (int i = 0; i < IN_FEAT; i++)
      if (en_i && idx_i == IW'(i)) act_o = acts_i[i];
  end

  assign oob_o = en_i && ({1'b0, idx_i} >= (IW+1)'(IN_FEAT));
endmodule

module lut_layer_sequencer #(
  parameter int IN_FEAT  = 16,
  parameter int OUT_FEAT = 8,
  parameter int FAN_IN   = 4,
  parameter int BW       = 2,
  parameter int IW       = $clog2(IN_FEAT),
  localparam int AW      = FAN_IN * BW,
  localparam int NW      = (OUT_FEAT > 1) ? $clog2(OUT_FEAT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_FEAT*BW-1:0]    s_data,
  output logic [NW-1:0]            conn_addr,
  input  logic [FAN_IN*IW-1:0]     conn_data,
  output logic                     lut_en,
  output logic [NW-1:0]            lut_neuron,
  output logic [AW-1:0]            lut_addr,
  input  logic [BW-1:0]            lut_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_FEAT*BW-1:0]   m_data,
  output logic                     busy,
  output logic                     err_oob
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                       state_q;
  logic [IN_FEAT-1:0][BW-1:0]   in_q;
  logic [OUT_FEAT-1:0][BW-1:0]  m_data_q;
  logic [NW-1:0]                cnt_q, nd_q;
  logic                         vld_q, lut_en_q, s_ready_q, m_valid_q, busy_q, err_q;
  logic [FAN_IN-1:0]            oob;
  logic [FAN_IN-1:0][BW-1:0]    gath;

  for (genvar k = 0; k < FAN_IN; k++) begin : g_lane
    lut_fanin_lane #(.IN_FEAT(IN_FEAT), .IW(IW), .BW(BW)) u_lane (
      .acts_i (in_q),
      .idx_i  (conn_data[k*IW +: IW]),
      .en_i   (lut_en_q),
      .act_o  (gath[k]),
      .oob_o  (oob[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_q      <= '0;
      m_data_q  <= '0;
      cnt_q     <= '0;
      nd_q      <= '0;
      vld_q     <= 1'b0;
      lut_en_q  <= 1'b0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Read pipeline: lut_data belongs to the neuron addressed one cycle earlier.
      vld_q <= lut_en_q;
      nd_q  <= cnt_q;
      if (vld_q) m_data_q[nd_q] <= lut_data;
      unique case (state_q)
        IDLE: if (s_valid) begin
          in_q      <= s_data;
          cnt_q     <= '0;
          err_q     <= 1'b0;
          m_data_q  <= '0;
          lut_en_q  <= 1'b1;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= RUN;
        end
        RUN: begin
          if (|oob) err_q <= 1'b1;
          if (cnt_q == NW'(OUT_FEAT-1)) begin
            lut_en_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          m_valid_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: if (m_ready) begin
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign conn_addr  = cnt_q;
  assign lut_en     = lut_en_q;
  assign lut_neuron = cnt_q;
  assign lut_addr   = gath;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign busy       = busy_q;
  assign err_oob    = err_q;
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed + random bench for lut_layer_sequencer with a truth-table responder and scoreboard.

module tb_lut_layer_sequencer;
  localparam int IN_FEAT = 16, OUT_FEAT = 8, FAN_IN = 4, BW = 2, IW = 5;
  localparam int AW = FAN_IN*BW, NW = 3;

  logic                   clk = 1'b0, rst;
  logic                   s_valid, s_ready, lut_en, m_valid, m_ready, busy, err_oob;
  logic [IN_FEAT*BW-1:0]  s_data;
  logic [NW-1:0]          conn_addr, lut_neuron;
  logic [FAN_IN*IW-1:0]   conn_data;
  logic [AW-1:0]          lut_addr;
  logic [BW-1:0]          lut_data;
  logic [OUT_FEAT*BW-1:0] m_data;

  lut_layer_sequencer #(.IN_FEAT(IN_FEAT), .OUT_FEAT(OUT_FEAT), .FAN_IN(FAN_IN), .BW(BW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .conn_addr(conn_addr), .conn_data(conn_data), .lut_en(lut_en), .lut_neuron(lut_neuron),
    .lut_addr(lut_addr), .lut_data(lut_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] conn_tbl [OUT_FEAT][FAN_IN];

  always_comb begin
    conn_data = '0;
    for (int k = 0; k < FAN_IN; k++) conn_data[k*IW +: IW] = conn_tbl[conn_addr][k];
  end

  // Reference truth table: (sum of fan-in activations + neuron index) mod 4.
  function automatic logic [BW-1:0] lut_fn(int n, logic [AW-1:0] a);
    int s = n;
    for (int k = 0; k < FAN_IN; k++) s += int'(a[k*BW +: BW]);
    return BW'(s);
  endfunction

  function automatic logic [AW-1:0] addr_of(int n, logic [IN_FEAT*BW-1:0] v);
    logic [AW-1:0] a = '0;
    for (int k = 0; k < FAN_IN; k++)
      if (int'(conn_tbl[n][k]) < IN_FEAT) a[k*BW +: BW] = v[int'(conn_tbl[n][k])*BW +: BW];
    return a;
  endfunction

  function automatic logic [OUT_FEAT*BW-1:0] exp_out(logic [IN_FEAT*BW-1:0] v);
    logic [OUT_FEAT*BW-1:0] o = '0;
    for (int n = 0; n < OUT_FEAT; n++) o[n*BW +: BW] = lut_fn(n, addr_of(n, v));
    return o;
  endfunction

  // Truth-table memory: answers one cycle after lut_en, junk otherwise.
  always @(posedge clk)
    lut_data <= lut_en ? lut_fn(int'(lut_neuron), lut_addr) : BW'($urandom);

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [OUT_FEAT*BW-1:0] sb[$];
  int                     acc_t[$];
  logic [IN_FEAT*BW-1:0]  cur_in = '0;
  logic [AW-1:0]          addr_or, addr_n3;
  int cyc = 0, en_vec = 0, n_acc = 0, addr_err = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (lut_en) begin
        en_vec++;
        if (lut_addr !== addr_of(int'(lut_neuron), cur_in)) addr_err++;
        addr_or |= lut_addr;
        if (lut_neuron == 3'd3) addr_n3 = lut_addr;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("out_data", m_data, sb.pop_front());
        chk("en_per_vec", en_vec, OUT_FEAT);
      end
      if (s_valid && s_ready) begin
        sb.push_back(exp_out(s_data));
        cur_in = s_data;
        en_vec = 0;
        acc_t.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [IN_FEAT*BW-1:0] v);
    int t = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = v;
    do begin @(negedge clk); t++; end while (!s_ready && t < 100);
    chk("send_timeout", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(output int c);
    c = 0;
    while (!m_valid && c < 100) begin @(negedge clk); c++; end
  endtask

  logic [31:0]            r;
  logic [OUT_FEAT*BW-1:0] md;
  logic                   bad;
  int                     c, base, t;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    addr_or = '0; addr_n3 = '0;
    for (int n = 0; n < OUT_FEAT; n++)
      for (int k = 0; k < FAN_IN; k++) conn_tbl[n][k] = IW'((4*n + k) % 16);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_lut_en", lut_en, 0);
    chk("rst_err", err_oob, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_conn_addr", conn_addr, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset mid-RUN abandons the vector
    m_ready = 1'b1;
    r = $urandom; send(r);
    repeat (3) @(negedge clk);
    chk("midrun_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_busy", busy, 0);
    chk("arst_s_ready", s_ready, 1);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_lut_en", lut_en, 0);
    bad = 1'b0;
    repeat (15) begin @(negedge clk); bad |= m_valid; end
    chk("arst_no_mvalid", bad, 0);

    // All-zero activations, identity connectivity
    addr_or = '0;
    send('0);
    wait_mvalid(c);
    chk("latency", c, 10);
    chk("zero_mdata", m_data, 32'h0000E4E4);
    chk("zero_addr", addr_or, 0);
    chk("zero_err", err_oob, 0);
    @(negedge clk);
    chk("zero_release", m_valid, 0);
    chk("zero_idle", s_ready, 1);

    // Backpressure in DONE
    m_ready = 1'b0;
    r = $urandom; send(r);
    wait_mvalid(c);
    chk("bp_latency", c, 10);
    md = m_data; base = n_acc; bad = 1'b0;
    s_valid = 1'b1; s_data = ~r;
    repeat (20) begin
      @(negedge clk);
      bad |= !m_valid || (m_data !== md) || s_ready || lut_en;
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_accept", n_acc - base, 0);
    s_valid = 1'b0;
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", m_valid, 1);
    @(negedge clk);
    chk("bp_release", m_valid, 0);

    // Back-to-back throughput
    base = acc_t.size(); t = 0;
    @(posedge clk); #1 s_valid = 1'b1;
    while (acc_t.size() < base + 3 && t < 100) begin
      r = $urandom; s_data = r;
      @(posedge clk); #1; t++;
    end
    s_valid = 1'b0;
    chk("b2b_count", acc_t.size() >= base + 3, 1);
    if (acc_t.size() >= base + 3) begin
      chk("b2b_gap1", acc_t[base+1] - acc_t[base], 11);
      chk("b2b_gap2", acc_t[base+2] - acc_t[base+1], 11);
    end
    repeat (15) @(negedge clk);

    // Out-of-range fan-in index
    conn_tbl[3][2] = IW'(17);
    addr_n3 = '0;
    send('1);
    wait_mvalid(c);
    chk("oob_addr_lo", addr_n3[5:4], 0);
    chk("oob_addr_hi", addr_n3[7:6], 3);
    chk("oob_mdata", m_data, 32'h0000E424);
    chk("oob_err_done", err_oob, 1);
    @(negedge clk);
    chk("oob_idle", s_ready, 1);
    chk("oob_err_hold", err_oob, 1);
    conn_tbl[3][2] = IW'(14);
    r = $urandom; send(r);
    chk("oob_err_clear", err_oob, 0);
    wait_mvalid(c);
    chk("oob_err_clean", err_oob, 0);
    repeat (3) @(negedge clk);

    // Random traffic with gaps and random backpressure
    for (int n = 0; n < OUT_FEAT; n++)
      for (int k = 0; k < FAN_IN; k++) conn_tbl[n][k] = IW'($urandom_range(0, 19));
    base = n_acc; t = 0;
    while (n_acc < base + 1000 && t < 40000) begin
      @(posedge clk); #1;
      s_valid = ($urandom_range(0, 3) != 0);
      r = $urandom; s_data = r;
      m_ready = $urandom_range(0, 1);
      t++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rand_done", n_acc - base >= 1000, 1);
    chk("sb_empty", sb.size(), 0);
    chk("addr_err", addr_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
